hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core. Drives every stage write-enable, flush and bubble in one place.
- Sequences three hazards: data-memory wait (freezes the whole pipe), taken branch/jump (multi-cycle front-end flush), load-use (one-cycle stall).
- Works alongside the EX forwarding logic. It handles only the hazards that forwarding cannot resolve.
- Adds a timeout-protected error state for an unresponsive data memory.

Parameters:
- TIMEOUT_CYCLES, 16, consecutive not-ready cycles in MEM_WAIT before entering ERROR (range 2..255).
- FLUSH_CYCLES, 2, cycles the IF/ID flush is held after a taken branch (range 1..7; covers synchronous IMEM latency).
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- id_ex_memRead  in  1  instruction in EX is a load.
- id_ex_rd  in  5  destination register of the instruction in EX.
- if_id_rs1  in  5  rs1 of the instruction in ID.
- if_id_rs2  in  5  rs2 of the instruction in ID.
- if_id_use_rs2  in  1  instruction in ID reads rs2.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- ex_mem_memAccess  in  1  MEM stage holds a load/store.
- dmem_ready  in  1  data memory completes the access this cycle.
- err_clear  in  1  exits ERROR.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_write  out  1  ID/EX register enable.
- id_ex_bubble  out  1  ID/EX loads a NOP.
- ex_mem_write  out  1  EX/MEM register enable.
- mem_wb_bubble  out  1  MEM/WB loads a NOP.
- mem_timeout  out  1  high while in ERROR.
- hazard_state  out  2  current state: 0 RUN, 1 MEM_WAIT, 2 FLUSH, 3 ERROR.

Behaviour:
- Defaults ("NORMAL" outputs): all *_write=1, all flush/bubble=0.
- Outputs are combinational from state, internal counters and inputs.
- While rst=1, every output is 0. On reset, state=RUN and wait_cnt, flush_cnt, flush_rem are all 0.
- Condition definitions:
  - memstall = ex_mem_memAccess & ~dmem_ready.
  - loaduse = id_ex_memRead & (id_ex_rd!=0) & (id_ex_rd==if_id_rs1 | (if_id_use_rs2 & id_ex_rd==if_id_rs2)).
- Priority: memstall > ex_branch_taken > loaduse.
- FREEZE outputs: pc_write, if_id_write, id_ex_write and ex_mem_write all 0; mem_wb_bubble=1; everything else 0.
- RUN:
  - memstall: FREEZE; next MEM_WAIT; wait_cnt<=1; flush_rem<=0.
  - else ex_branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1. If FLUSH_CYCLES>1, next FLUSH with flush_cnt<=1; else stay in RUN.
  - else loaduse: pc_write=0, if_id_write=0, id_ex_bubble=1; stay in RUN. The hazard clears the next cycle because the load has advanced.
  - else NORMAL.
- MEM_WAIT:
  - dmem_ready=0: FREEZE; wait_cnt++. If wait_cnt==TIMEOUT_CYCLES-1, next ERROR.
  - dmem_ready=1 (release cycle): pipe advances.
    - If flush_rem!=0: FLUSH outputs; next FLUSH.
    - Else evaluate branch and load-use exactly as in RUN (memstall is false by definition); next RUN or FLUSH.
  - wait_cnt clears on leaving the state.
- FLUSH:
  - Outputs: pc_write=1, if_id_flush=1, id_ex_bubble=1, other writes 1.
  - flush_cnt++ each cycle; next RUN when flush_cnt==FLUSH_CYCLES-1.
  - memstall in FLUSH: FREEZE; flush_rem<=FLUSH_CYCLES-flush_cnt; next MEM_WAIT. The flush resumes after release with the remaining count and does not restart.
  - A new ex_branch_taken in FLUSH: ignored, because the EX instruction is already flushed.
- ERROR: all *_write=0, all flush/bubble=0, mem_timeout=1. Next RUN when err_clear=1, with counters cleared.
- Load-use with id_ex_rd==0 never stalls. A stalled load and a taken branch cannot coexist in EX, so the branch always wins.
- Reset mid-operation (any state): outputs go to 0 immediately; state returns to RUN.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Adds output ports stall_cycles [CNT_W-1:0] and flush_cycles [CNT_W-1:0].
  - stall_cycles increments on every FREEZE or load-use stall cycle.
  - flush_cycles increments on every cycle with if_id_flush=1.
  - Both counters saturate at all-ones and clear on rst.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Load-use: id_ex_memRead=1, id_ex_rd=5, if_id_rs1=5 for 1 cycle → pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle. Then with id_ex_memRead=0 → NORMAL. Repeat with rd=0 → no stall.
- Taken branch, FLUSH_CYCLES=2: pulse ex_branch_taken → if_id_flush=1 for exactly 2 cycles, hazard_state goes 0→2→0, pc_write=1 throughout.
- Memory wait: ex_mem_memAccess=1, dmem_ready low 3 cycles then high → 3 FREEZE cycles (mem_wb_bubble=1), hazard_state=1. Release cycle is NORMAL, then RUN.
- Timeout: dmem_ready held 0 with TIMEOUT_CYCLES=16 → ERROR entered after 16 frozen cycles, mem_timeout=1. err_clear pulse → RUN, NORMAL outputs.
- Stall during flush: branch taken, then memstall on 2nd FLUSH cycle for 2 cycles → FREEZE 2 cycles, then exactly 1 remaining flush cycle, then RUN. Assert rst mid-MEM_WAIT → all outputs 0 immediately, hazard_state=0 after release.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
// Central hazard sequencer for the 5-stage RISC-V pipeline. Produces every
// stage write-enable, flush and bubble from one state machine that handles
// data-memory waits (full freeze), taken branches (multi-cycle IF/ID flush)
// and load-use (one-cycle stall), plus a timeout error for a dead data memory.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush counters.
module hazard_ctrl_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned FLUSH_CYCLES   = 2
`ifdef HAZARD_PERF_EN
  ,
  parameter int unsigned CNT_W          = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_ex_memRead,
  input  logic [4:0] id_ex_rd,
  input  logic [4:0] if_id_rs1,
  input  logic [4:0] if_id_rs2,
  input  logic       if_id_use_rs2,
  input  logic       ex_branch_taken,
  input  logic       ex_mem_memAccess,
  input  logic       dmem_ready,
  input  logic       err_clear,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_write,
  output logic       id_ex_bubble,
  output logic       ex_mem_write,
  output logic       mem_wb_bubble,
  output logic       mem_timeout,
  output logic [1:0] hazard_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
`endif
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FLUSH    = 2'd2,
    S_ERROR    = 2'd3
  } state_e;

  // One bundle of pipeline controls so each situation is a single constant.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL  = 7'b1101010;
  localparam ctrl_t CTRL_FREEZE  = 7'b0000001;
  localparam ctrl_t CTRL_FLUSH   = 7'b1111110;
  localparam ctrl_t CTRL_LOADUSE = 7'b0001110;
  localparam ctrl_t CTRL_OFF     = 7'b0000000;

  localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] FLUSH_N     = 3'(FLUSH_CYCLES);
  localparam logic [2:0] FLUSH_LAST  = 3'(FLUSH_CYCLES - 1);
  localparam logic       MULTI_FLUSH = (FLUSH_CYCLES > 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic [2:0] flush_rem_q, flush_rem_d;

  logic  memstall;
  logic  loaduse;
  ctrl_t fresh_ctrl;
  logic  fresh_flush;
  ctrl_t ctrl;
  logic  timeout;
  ctrl_t ctrl_out;

  assign memstall = ex_mem_memAccess & ~dmem_ready;
  assign loaduse  = id_ex_memRead & (id_ex_rd != 5'd0) &
                    ((id_ex_rd == if_id_rs1) | (if_id_use_rs2 & (id_ex_rd == if_id_rs2)));

  // Branch / load-use decision for a cycle in which the pipe is free to advance.
  always_comb begin
    fresh_ctrl  = CTRL_NORMAL;
    fresh_flush = 1'b0;
    if (ex_branch_taken) begin
      fresh_ctrl  = CTRL_FLUSH;
      fresh_flush = MULTI_FLUSH;
    end else if (loaduse) begin
      fresh_ctrl = CTRL_LOADUSE;
    end
  end

  // Next-state, counter updates and control outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    flush_rem_d = flush_rem_q;
    ctrl        = CTRL_NORMAL;
    timeout     = 1'b0;

    case (state_q)
      S_RUN: begin
        if (memstall) begin
          ctrl        = CTRL_FREEZE;
          state_d     = S_MEM_WAIT;
          wait_cnt_d  = 8'd1;
          flush_rem_d = 3'd0;
        end else begin
          ctrl = fresh_ctrl;
          if (fresh_flush) begin
            state_d     = S_FLUSH;
            flush_cnt_d = 3'd1;
          end
        end
      end

      S_MEM_WAIT: begin
        if (!dmem_ready) begin
          ctrl       = CTRL_FREEZE;
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d    = S_ERROR;
            wait_cnt_d = 8'd0;
          end
        end else begin
          // Release cycle: the pipe advances and the wait counter retires.
          wait_cnt_d  = 8'd0;
          flush_rem_d = 3'd0;
          if (flush_rem_q != 3'd0) begin
            // This cycle is the first of the remaining flush cycles.
            ctrl = CTRL_FLUSH;
            if (flush_rem_q > 3'd1) begin
              state_d     = S_FLUSH;
              flush_cnt_d = FLUSH_N - flush_rem_q + 3'd1;
            end else begin
              state_d     = S_RUN;
              flush_cnt_d = 3'd0;
            end
          end else begin
            ctrl        = fresh_ctrl;
            state_d     = fresh_flush ? S_FLUSH : S_RUN;
            flush_cnt_d = fresh_flush ? 3'd1 : 3'd0;
          end
        end
      end

      S_FLUSH: begin
        if (memstall) begin
          // Remember how much flushing is still owed; it resumes after release.
          ctrl        = CTRL_FREEZE;
          flush_rem_d = FLUSH_N - flush_cnt_q;
          flush_cnt_d = 3'd0;
          wait_cnt_d  = 8'd1;
          state_d     = S_MEM_WAIT;
        end else begin
          ctrl        = CTRL_FLUSH;
          flush_cnt_d = flush_cnt_q + 3'd1;
          if (flush_cnt_q == FLUSH_LAST) begin
            state_d     = S_RUN;
            flush_cnt_d = 3'd0;
          end
        end
      end

      S_ERROR: begin
        ctrl    = CTRL_OFF;
        timeout = 1'b1;
        if (err_clear) begin
          state_d     = S_RUN;
          wait_cnt_d  = 8'd0;
          flush_cnt_d = 3'd0;
          flush_rem_d = 3'd0;
        end
      end
    endcase
  end

  // Reset forces every control low immediately, independent of the clock.
  always_comb begin
    ctrl_out = rst ? CTRL_OFF : ctrl;
  end

  assign pc_write      = ctrl_out.pc_write;
  assign if_id_write   = ctrl_out.if_id_write;
  assign if_id_flush   = ctrl_out.if_id_flush;
  assign id_ex_write   = ctrl_out.id_ex_write;
  assign id_ex_bubble  = ctrl_out.id_ex_bubble;
  assign ex_mem_write  = ctrl_out.ex_mem_write;
  assign mem_wb_bubble = ctrl_out.mem_wb_bubble;
  assign mem_timeout   = timeout & ~rst;
  assign hazard_state  = rst ? 2'd0 : state_q;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= 8'd0;
      flush_cnt_q <= 3'd0;
      flush_rem_q <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      flush_rem_q <= flush_rem_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic             stall_evt;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  assign stall_evt    = (ctrl_out == CTRL_FREEZE) | (ctrl_out == CTRL_LOADUSE);
  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (ctrl_out.if_id_flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios plus a
// randomized run against a behavioural model kept in terms of frozen-cycle
// counts and owed flush cycles.
module tb_hazard_ctrl_unit;

  localparam int TO = 16;
  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_ex_memRead;
  logic [4:0] id_ex_rd;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic       if_id_use_rs2;
  logic       ex_branch_taken;
  logic       ex_mem_memAccess;
  logic       dmem_ready;
  logic       err_clear;
  logic       pc_write, if_id_write, if_id_flush, id_ex_write;
  logic       id_ex_bubble, ex_mem_write, mem_wb_bubble, mem_timeout;
  logic [1:0] hazard_state;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_cycles;
`endif

  always #5 clk = ~clk;

  hazard_ctrl_unit #(
    .TIMEOUT_CYCLES(TO),
    .FLUSH_CYCLES  (FC)
`ifdef HAZARD_PERF_EN
    ,
    .CNT_W         (16)
`endif
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_ex_memRead   (id_ex_memRead),
    .id_ex_rd        (id_ex_rd),
    .if_id_rs1       (if_id_rs1),
    .if_id_rs2       (if_id_rs2),
    .if_id_use_rs2   (if_id_use_rs2),
    .ex_branch_taken (ex_branch_taken),
    .ex_mem_memAccess(ex_mem_memAccess),
    .dmem_ready      (dmem_ready),
    .err_clear       (err_clear),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_write     (id_ex_write),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_write    (ex_mem_write),
    .mem_wb_bubble   (mem_wb_bubble),
    .mem_timeout     (mem_timeout),
    .hazard_state    (hazard_state)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_cycles    (flush_cycles)
`endif
  );

  // Observed vector: pc, ifw, iff, idw, idb, exw, mwb, timeout, state[1:0]
  logic [10:0] obs;
  assign obs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
                ex_mem_write, mem_wb_bubble, mem_timeout, hazard_state};

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u2;
    logic       br;
    logic       ma;
    logic       rdy;
    logic       clr;
  } stim_t;

  function automatic stim_t mk(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u2, input logic br,
                               input logic ma, input logic rdy, input logic clr);
    stim_t s;
    s.mr = mr; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.u2 = u2;
    s.br = br; s.ma = ma; s.rdy = rdy; s.clr = clr;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic stim_t mem(input logic ma, input logic rdy);
    return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ma, rdy, 1'b0);
  endfunction

  function automatic stim_t brs();
    return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endfunction

  // Expected output vectors for each pipeline situation.
  function automatic logic [10:0] e_norm(input logic [1:0] st);   return {7'b1101010, 1'b0, st}; endfunction
  function automatic logic [10:0] e_freeze(input logic [1:0] st); return {7'b0000001, 1'b0, st}; endfunction
  function automatic logic [10:0] e_flush(input logic [1:0] st);  return {7'b1111110, 1'b0, st}; endfunction
  function automatic logic [10:0] e_lu(input logic [1:0] st);     return {7'b0001110, 1'b0, st}; endfunction
  function automatic logic [10:0] e_err();                        return {7'b0000000, 1'b1, 2'd3}; endfunction

  task automatic drive(input stim_t s);
    id_ex_memRead    = s.mr;
    id_ex_rd         = s.rd;
    if_id_rs1        = s.rs1;
    if_id_rs2        = s.rs2;
    if_id_use_rs2    = s.u2;
    ex_branch_taken  = s.br;
    ex_mem_memAccess = s.ma;
    dmem_ready       = s.rdy;
    err_clear        = s.clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(idle());
    #2;
    n_checks++;
    if (obs !== 11'd0) begin
      n_fail++; $display("FAIL reset_idle: got %b expected %b", obs, 11'd0);
    end
    tick();
    drive(mem(1'b1, 1'b0));
    #1;
    n_checks++;
    if (obs !== 11'd0) begin
      n_fail++; $display("FAIL reset_masks_freeze: got %b expected %b", obs, 11'd0);
    end
    drive(idle());
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== e_norm(2'd0)) begin
      n_fail++; $display("FAIL reset_release: got %b expected %b", obs, e_norm(2'd0));
    end
    tick();
  endtask

  task automatic test_load_use();
    stim_t       s[6];
    logic [10:0] e[6];
    s[0] = mk(1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 1, 0); e[0] = e_lu(2'd0);
    s[1] = mk(0, 5'd5, 5'd5, 5'd0, 0, 0, 0, 1, 0); e[1] = e_norm(2'd0);
    s[2] = mk(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1, 0); e[2] = e_norm(2'd0);
    s[3] = mk(1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 1, 0); e[3] = e_lu(2'd0);
    s[4] = mk(1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 1, 0); e[4] = e_norm(2'd0);
    s[5] = mk(1, 5'd9, 5'd9, 5'd0, 0, 1, 0, 1, 0); e[5] = e_flush(2'd0);
    for (int i = 0; i < 6; i++) begin
      drive(s[i]);
      #1;
      n_checks++;
      if (obs !== e[i]) begin
        n_fail++; $display("FAIL load_use[%0d]: got %b expected %b", i, obs, e[i]);
      end
      tick();
      if (i == 5) begin
        drive(idle());
        tick();
      end
    end
  endtask

  task automatic test_branch();
    stim_t       s[7];
    logic [10:0] e[7];
    s[0] = brs();  e[0] = e_flush(2'd0);
    s[1] = idle(); e[1] = e_flush(2'd2);
    s[2] = idle(); e[2] = e_norm(2'd0);
    s[3] = brs();  e[3] = e_flush(2'd0);
    s[4] = brs();  e[4] = e_flush(2'd2);
    s[5] = idle(); e[5] = e_norm(2'd0);
    s[6] = idle(); e[6] = e_norm(2'd0);
    for (int i = 0; i < 7; i++) begin
      drive(s[i]);
      #1;
      n_checks++;
      if (obs !== e[i]) begin
        n_fail++; $display("FAIL branch[%0d]: got %b expected %b", i, obs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    stim_t       s[5];
    logic [10:0] e[5];
    s[0] = mem(1, 0); e[0] = e_freeze(2'd0);
    s[1] = mem(1, 0); e[1] = e_freeze(2'd1);
    s[2] = mem(1, 0); e[2] = e_freeze(2'd1);
    s[3] = mem(1, 1); e[3] = e_norm(2'd1);
    s[4] = mem(0, 1); e[4] = e_norm(2'd0);
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      #1;
      n_checks++;
      if (obs !== e[i]) begin
        n_fail++; $display("FAIL mem_wait[%0d]: got %b expected %b", i, obs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    logic [10:0] e;
    for (int i = 0; i < TO; i++) begin
      drive(mem(1, 0));
      #1;
      e = e_freeze((i == 0) ? 2'd0 : 2'd1);
      n_checks++;
      if (obs !== e) begin
        n_fail++; $display("FAIL timeout_freeze[%0d]: got %b expected %b", i, obs, e);
      end
      tick();
    end
    drive(mem(1, 1));
    #1;
    n_checks++;
    if (obs !== e_err()) begin
      n_fail++; $display("FAIL timeout_error: got %b expected %b", obs, e_err());
    end
    tick();
    drive(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1));
    #1;
    n_checks++;
    if (obs !== e_err()) begin
      n_fail++; $display("FAIL timeout_clear_cycle: got %b expected %b", obs, e_err());
    end
    tick();
    drive(idle());
    #1;
    n_checks++;
    if (obs !== e_norm(2'd0)) begin
      n_fail++; $display("FAIL timeout_recovered: got %b expected %b", obs, e_norm(2'd0));
    end
    tick();
  endtask

  task automatic test_stall_in_flush();
    stim_t       s[6];
    logic [10:0] e[6];
    s[0] = brs();     e[0] = e_flush(2'd0);
    s[1] = mem(1, 0); e[1] = e_freeze(2'd2);
    s[2] = mem(1, 0); e[2] = e_freeze(2'd1);
    s[3] = mem(1, 1); e[3] = e_flush(2'd1);
    s[4] = idle();    e[4] = e_norm(2'd0);
    s[5] = idle();    e[5] = e_norm(2'd0);
    for (int i = 0; i < 6; i++) begin
      drive(s[i]);
      #1;
      n_checks++;
      if (obs !== e[i]) begin
        n_fail++; $display("FAIL stall_in_flush[%0d]: got %b expected %b", i, obs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(mem(1, 0));
    tick();
    #1;
    n_checks++;
    if (obs !== e_freeze(2'd1)) begin
      n_fail++; $display("FAIL reset_mid_wait: got %b expected %b", obs, e_freeze(2'd1));
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 11'd0) begin
      n_fail++; $display("FAIL reset_mid_immediate: got %b expected %b", obs, 11'd0);
    end
    tick();
    drive(idle());
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== e_norm(2'd0)) begin
      n_fail++; $display("FAIL reset_mid_release: got %b expected %b", obs, e_norm(2'd0));
    end
    tick();
  endtask

  // Behavioural reference: mode, frozen-cycle count, flush cycles still owed
  // in the current flush, flush cycles owed after a memory wait.
  int m_mode, m_frozen, m_owed, m_resume;
  int n_mode, n_frozen, n_owed, n_resume;
  int m_stalls, m_flushes;

  task automatic model_step(output logic [10:0] exp);
    bit ms, lu;
    logic [1:0] st;
    ms = ex_mem_memAccess && !dmem_ready;
    lu = id_ex_memRead && (id_ex_rd != 0) &&
         ((id_ex_rd == if_id_rs1) || (if_id_use_rs2 && (id_ex_rd == if_id_rs2)));
    n_mode = m_mode; n_frozen = m_frozen; n_owed = m_owed; n_resume = m_resume;
    st = 2'(m_mode);
    exp = e_norm(st);
    if (m_mode == 3) begin
      exp = e_err();
      if (err_clear) begin n_mode = 0; n_frozen = 0; n_owed = 0; n_resume = 0; end
    end else if (m_mode == 2) begin
      if (ms) begin
        exp = e_freeze(st); n_resume = m_owed; n_frozen = 1; n_mode = 1;
      end else begin
        exp = e_flush(st); n_owed = m_owed - 1;
        if (n_owed == 0) n_mode = 0;
      end
    end else if (m_mode == 1 && !dmem_ready) begin
      exp = e_freeze(st); n_frozen = m_frozen + 1;
      if (n_frozen == TO) n_mode = 3;
    end else if (m_mode == 1 && m_resume > 0) begin
      exp = e_flush(st); n_owed = m_resume - 1; n_resume = 0;
      n_mode = (n_owed > 0) ? 2 : 0;
    end else if (m_mode == 0 && ms) begin
      exp = e_freeze(st); n_mode = 1; n_frozen = 1; n_resume = 0;
    end else begin
      // Pipe is free to advance (RUN, or memory release with nothing owed).
      n_mode = 0; n_frozen = 0;
      if (ex_branch_taken) begin
        exp = e_flush(st); n_owed = FC - 1;
        if (n_owed > 0) n_mode = 2;
      end else if (lu) begin
        exp = e_lu(st);
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] exp;
    bit slow;
    rst = 1'b1;
    drive(idle());
    tick();
    rst = 1'b0;
    m_mode = 0; m_frozen = 0; m_owed = 0; m_resume = 0; m_stalls = 0; m_flushes = 0;
    for (int i = 0; i < 2400; i++) begin
      slow = ((i / 64) % 3) == 2;
      id_ex_memRead    = 1'($urandom_range(0, 1));
      id_ex_rd         = 5'($urandom_range(0, 3));
      if_id_rs1        = 5'($urandom_range(0, 3));
      if_id_rs2        = 5'($urandom_range(0, 3));
      if_id_use_rs2    = 1'($urandom_range(0, 1));
      ex_branch_taken  = ($urandom_range(0, 4) == 0);
      ex_mem_memAccess = slow ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
      dmem_ready       = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 4) != 0);
      err_clear        = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 11'd0) begin
          n_fail++; $display("FAIL random_reset[%0d]: got %b expected %b", i, obs, 11'd0);
        end
        tick();
        rst = 1'b0;
        m_mode = 0; m_frozen = 0; m_owed = 0; m_resume = 0; m_stalls = 0; m_flushes = 0;
      end else begin
        model_step(exp);
        #1;
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL random[%0d]: got %b expected %b", i, obs, exp);
        end
        tick();
        if (exp[4] || (exp[10:4] == 7'b0001110)) m_stalls++;
        if (exp[8]) m_flushes++;
        m_mode = n_mode; m_frozen = n_frozen; m_owed = n_owed; m_resume = n_resume;
      end
    end
`ifdef HAZARD_PERF_EN
    #1;
    n_checks++;
    if (stall_cycles !== 16'(m_stalls)) begin
      n_fail++; $display("FAIL perf_stall: got %0d expected %0d", stall_cycles, m_stalls);
    end
    n_checks++;
    if (flush_cycles !== 16'(m_flushes)) begin
      n_fail++; $display("FAIL perf_flush: got %0d expected %0d", flush_cycles, m_flushes);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_stall_in_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
